// File: rtl/uart_frame_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_frame_receiver                                          |
// | Description : 8N1 UART byte receiver feeding a '!'/'#' framed-packet parser|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_frame_receiver #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 57600,
    parameter int MAX_LEN   = 16
) (
    input  logic                 CLK100MHZ,
    input  logic                 reset,
    input  logic                 Uart_RXD,
    output logic                 frame_valid,
    output logic                 frame_type,
    output logic [7:0]           frame_len,
    output logic [MAX_LEN*8-1:0] frame_data,
    output logic                 frame_error,
    output logic                 rx_busy
);

    localparam int c_CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int c_CNT_W        = $clog2(c_CLKS_PER_BIT + 1);
    localparam logic [c_CNT_W-1:0] c_HALF_BIT = c_CNT_W'(c_CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_BIT = c_CNT_W'(c_CLKS_PER_BIT - 1);
    localparam logic [9:0]         c_MAX_LEN  = 10'(MAX_LEN);

    localparam logic [1:0] c_RX_IDLE  = 2'd0;
    localparam logic [1:0] c_RX_START = 2'd1;
    localparam logic [1:0] c_RX_DATA  = 2'd2;
    localparam logic [1:0] c_RX_STOP  = 2'd3;

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_CMD_LEN  = 3'd1;
    localparam logic [2:0] c_BIN_NDIG = 3'd2;
    localparam logic [2:0] c_BIN_LEN  = 3'd3;
    localparam logic [2:0] c_PAYLOAD  = 3'd4;
    localparam logic [2:0] c_ESCAPE   = 3'd5;
    localparam logic [2:0] c_WAIT_CR  = 3'd6;
    localparam logic [2:0] c_WAIT_LF  = 3'd7;

    // Synchronizer resets low so a line held low across reset release is not seen as a start edge
    logic r_rxd_meta, r_rxd_sync, r_rxd_prev;
    logic w_fall;

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_rxd_meta <= 1'b0;
            r_rxd_sync <= 1'b0;
            r_rxd_prev <= 1'b0;
        end else begin
            r_rxd_meta <= Uart_RXD;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
        end
    end

    assign w_fall = r_rxd_prev & ~r_rxd_sync;

    logic [1:0]         r_rx_state, w_rx_state_next;
    logic [c_CNT_W-1:0] r_clk_cnt,  w_clk_cnt_next;
    logic [2:0]         r_bit_cnt,  w_bit_cnt_next;
    logic [7:0]         r_shift,    w_shift_next;
    logic               w_byte_valid, w_stop_error;
    logic [7:0]         w_byte_data;

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_clk_cnt_next  = r_clk_cnt + 1'b1;
        w_bit_cnt_next  = r_bit_cnt;
        w_shift_next    = r_shift;
        w_byte_valid    = 1'b0;
        w_stop_error    = 1'b0;
        case (r_rx_state)
            c_RX_IDLE: begin
                w_clk_cnt_next = '0;
                if (w_fall) w_rx_state_next = c_RX_START;
            end
            c_RX_START: begin
                if (r_clk_cnt == c_HALF_BIT) begin
                    w_clk_cnt_next  = '0;
                    w_bit_cnt_next  = '0;
                    w_rx_state_next = r_rxd_sync ? c_RX_IDLE : c_RX_DATA;
                end
            end
            c_RX_DATA: begin
                if (r_clk_cnt == c_FULL_BIT) begin
                    w_clk_cnt_next = '0;
                    w_shift_next   = {r_rxd_sync, r_shift[7:1]};
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 3'd7) w_rx_state_next = c_RX_STOP;
                end
            end
            default: begin
                // After a low stop bit, the edge detector needs the line high again before the next start
                if (r_clk_cnt == c_FULL_BIT) begin
                    w_rx_state_next = c_RX_IDLE;
                    w_byte_valid    = r_rxd_sync;
                    w_stop_error    = ~r_rxd_sync;
                end
            end
        endcase
    end

    assign w_byte_data = r_shift;

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_rx_state <= c_RX_IDLE;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            r_rx_state <= w_rx_state_next;
            r_clk_cnt  <= w_clk_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
        end
    end

    logic [2:0]           r_state, w_state_next;
    logic [9:0]           r_len,   w_len_next;
    logic [1:0]           r_ndig,  w_ndig_next;
    logic [9:0]           r_count, w_count_next;
    logic                 r_type,  w_type_next;
    logic [MAX_LEN*8-1:0] r_buf,   w_buf_next;
    logic                 w_store, w_accept, w_error, w_is_digit;
    logic [3:0]           w_digit;
    logic [9:0]           w_len_acc;
    logic                 r_frame_valid, r_frame_type, r_frame_error;
    logic [7:0]           r_frame_len;
    logic [MAX_LEN*8-1:0] r_frame_data;

    assign w_is_digit = (w_byte_data >= 8'h30) && (w_byte_data <= 8'h39);
    assign w_digit    = w_byte_data[3:0];
    assign w_len_acc  = 10'(r_len * 10'd10) + {6'd0, w_digit};

    always_comb begin
        w_state_next = r_state;
        w_len_next   = r_len;
        w_ndig_next  = r_ndig;
        w_count_next = r_count;
        w_type_next  = r_type;
        w_buf_next   = r_buf;
        w_store      = 1'b0;
        w_accept     = 1'b0;
        w_error      = w_stop_error;
        if (w_byte_valid) begin
            case (r_state)
                c_IDLE: begin
                    if (w_byte_data == 8'h21 || w_byte_data == 8'h23) begin
                        w_state_next = (w_byte_data == 8'h21) ? c_CMD_LEN : c_BIN_NDIG;
                        w_type_next  = (w_byte_data == 8'h23);
                        w_buf_next   = '0;
                        w_len_next   = '0;
                        w_count_next = '0;
                    end
                end
                c_CMD_LEN: begin
                    if (w_is_digit && w_digit != 4'd0) begin
                        w_len_next   = {6'd0, w_digit};
                        w_state_next = c_PAYLOAD;
                    end else begin
                        w_error = 1'b1;
                    end
                end
                c_BIN_NDIG: begin
                    if (w_byte_data >= 8'h31 && w_byte_data <= 8'h33) begin
                        w_ndig_next  = w_byte_data[1:0];
                        w_len_next   = '0;
                        w_state_next = c_BIN_LEN;
                    end else begin
                        w_error = 1'b1;
                    end
                end
                c_BIN_LEN: begin
                    if (!w_is_digit) begin
                        w_error = 1'b1;
                    end else begin
                        w_len_next  = w_len_acc;
                        w_ndig_next = r_ndig - 1'b1;
                        if (r_ndig == 2'd1) begin
                            if (w_len_acc == 10'd0)          w_state_next = c_WAIT_CR;
                            else if (w_len_acc > c_MAX_LEN)  w_error      = 1'b1;
                            else                             w_state_next = c_PAYLOAD;
                        end
                    end
                end
                c_PAYLOAD: begin
                    if (r_type && w_byte_data == 8'h10) w_state_next = c_ESCAPE;
                    else                                w_store      = 1'b1;
                end
                c_ESCAPE:  w_store = 1'b1;
                c_WAIT_CR: begin
                    if (w_byte_data == 8'h0D) w_state_next = c_WAIT_LF;
                    else                      w_error      = 1'b1;
                end
                default: begin
                    if (w_byte_data == 8'h0A) begin
                        w_accept     = 1'b1;
                        w_state_next = c_IDLE;
                    end else begin
                        w_error = 1'b1;
                    end
                end
            endcase
        end
        if (w_store) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                if (r_count == 10'(k)) w_buf_next[k*8 +: 8] = w_byte_data;
            end
            w_count_next = r_count + 1'b1;
            w_state_next = (r_count + 1'b1 == r_len) ? c_WAIT_CR : c_PAYLOAD;
        end
        if (w_error) begin
            w_state_next = c_IDLE;
            w_buf_next   = '0;
        end
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_len         <= '0;
            r_ndig        <= '0;
            r_count       <= '0;
            r_type        <= 1'b0;
            r_buf         <= '0;
            r_frame_valid <= 1'b0;
            r_frame_error <= 1'b0;
            r_frame_type  <= 1'b0;
            r_frame_len   <= '0;
            r_frame_data  <= '0;
        end else begin
            r_state       <= w_state_next;
            r_len         <= w_len_next;
            r_ndig        <= w_ndig_next;
            r_count       <= w_count_next;
            r_type        <= w_type_next;
            r_buf         <= w_buf_next;
            r_frame_valid <= w_accept;
            r_frame_error <= w_error;
            if (w_accept) begin
                r_frame_type <= r_type;
                r_frame_len  <= r_len[7:0];
                r_frame_data <= r_buf;
            end
        end
    end

    assign frame_valid = r_frame_valid;
    assign frame_error = r_frame_error;
    assign frame_type  = r_frame_type;
    assign frame_len   = r_frame_len;
    assign frame_data  = r_frame_data;
    assign rx_busy     = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_frame_receiver                                       |
// | Description : Directed and randomized frame traffic for uart_frame_receiver|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_frame_receiver;

    localparam int c_CLK_FREQ = 50_000_000;
    localparam int c_BAUD     = 1_000_000;
    localparam int c_MAX_LEN  = 16;
    localparam int c_BIT      = c_CLK_FREQ / c_BAUD;
    localparam int c_W        = c_MAX_LEN * 8;

    logic             CLK100MHZ = 1'b0;
    logic             reset     = 1'b1;
    logic             Uart_RXD  = 1'b1;
    logic             frame_valid, frame_type, frame_error, rx_busy;
    logic [7:0]       frame_len;
    logic [c_W-1:0]   frame_data;

    uart_frame_receiver #(
        .CLK_FREQ (c_CLK_FREQ),
        .BAUD_RATE(c_BAUD),
        .MAX_LEN  (c_MAX_LEN)
    ) dut (
        .CLK100MHZ  (CLK100MHZ),
        .reset      (reset),
        .Uart_RXD   (Uart_RXD),
        .frame_valid(frame_valid),
        .frame_type (frame_type),
        .frame_len  (frame_len),
        .frame_data (frame_data),
        .frame_error(frame_error),
        .rx_busy    (rx_busy)
    );

    always #10 CLK100MHZ = ~CLK100MHZ;

    int compared   = 0;
    int mismatched = 0;
    int n_valid = 0, n_err = 0, n_both = 0;
    int exp_valid = 0, exp_err = 0;
    logic           exp_type = 1'b0;
    logic [7:0]     exp_len  = '0;
    logic [c_W-1:0] exp_data = '0;
    byte unsigned   tx_q[$];
    byte unsigned   pay[$];

    // Pulse counters: a pulse longer than one cycle shows up as an extra count
    always @(negedge CLK100MHZ) begin
        if (!reset) begin
            if (frame_valid) n_valid++;
            if (frame_error) n_err++;
            if (frame_valid && frame_error) n_both++;
        end
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: time limit reached, observed no end of stimulus, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [c_W-1:0] obs, input logic [c_W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        Uart_RXD = v;
        repeat (c_BIT) @(negedge CLK100MHZ);
    endtask

    task automatic send_byte(input byte unsigned b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        if (!stop) send_bit(1'b1);
    endtask

    task automatic send_q();
        while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) tx_q.push_back(s[i]);
    endtask

    task automatic push_pay(input logic escape_dle);
        for (int i = 0; i < pay.size(); i++) begin
            if (escape_dle && pay[i] == 8'h10) tx_q.push_back(8'h10);
            tx_q.push_back(pay[i]);
        end
    endtask

    task automatic expect_frame(input logic t);
        exp_valid++;
        exp_type = t;
        exp_len  = 8'(pay.size());
        exp_data = '0;
        for (int k = 0; k < pay.size(); k++) exp_data[k*8 +: 8] = pay[k];
    endtask

    // Binary frame encoder: nd length digits with leading zeros, DLE bytes escaped
    task automatic build_bin(input int nd);
        int p = 1;
        tx_q.push_back(8'h23);
        tx_q.push_back(8'(8'h30 + nd));
        for (int d = 1; d < nd; d++) p *= 10;
        for (int d = 0; d < nd; d++) begin
            tx_q.push_back(8'(8'h30 + (pay.size() / p) % 10));
            p /= 10;
        end
        push_pay(1'b1);
        tx_q.push_back(8'h0D);
        tx_q.push_back(8'h0A);
        expect_frame(1'b1);
    endtask

    task automatic build_cmd();
        tx_q.push_back(8'h21);
        tx_q.push_back(8'(8'h30 + pay.size()));
        push_pay(1'b0);
        tx_q.push_back(8'h0D);
        tx_q.push_back(8'h0A);
        expect_frame(1'b0);
    endtask

    task automatic rand_pay(input int n);
        pay.delete();
        for (int i = 0; i < n; i++)
            pay.push_back(($urandom_range(0, 3) == 0) ? 8'h10 : 8'($urandom));
    endtask

    task automatic str_pay(input string s);
        pay.delete();
        for (int i = 0; i < s.len(); i++) pay.push_back(s[i]);
    endtask

    task automatic check_frame(input string tag);
        repeat (5) @(negedge CLK100MHZ);
        check({tag, ".valid_cnt"}, c_W'(n_valid), c_W'(exp_valid));
        check({tag, ".error_cnt"}, c_W'(n_err), c_W'(exp_err));
        check({tag, ".both"}, c_W'(n_both), c_W'(0));
        check({tag, ".type"}, c_W'(frame_type), c_W'(exp_type));
        check({tag, ".len"}, c_W'(frame_len), c_W'(exp_len));
        check({tag, ".data"}, frame_data, exp_data);
        check({tag, ".busy"}, c_W'(rx_busy), c_W'(0));
    endtask

    initial begin
        repeat (5) @(negedge CLK100MHZ);
        check("rst.valid", c_W'(frame_valid), c_W'(0));
        check("rst.error", c_W'(frame_error), c_W'(0));
        check("rst.type", c_W'(frame_type), c_W'(0));
        check("rst.len", c_W'(frame_len), c_W'(0));
        check("rst.data", frame_data, '0);
        check("rst.busy", c_W'(rx_busy), c_W'(0));
        reset = 1'b0;
        repeat (2 * c_BIT) @(negedge CLK100MHZ);

        pay = '{8'h01, 8'h04, 8'h19, 8'h99};
        build_bin(1); send_q(); check_frame("bin4");
        check("bin4.literal", frame_data, c_W'(32'h99190401));

        str_pay("WRITE REG");
        build_cmd(); send_q(); check_frame("cmd9");

        pay = '{8'h10, 8'h04, 8'h19, 8'h99};
        build_bin(1); send_q(); check_frame("bin_dle");
        check("bin_dle.literal", frame_data, c_W'(32'h99190410));

        // Bad terminator: rejected, previous frame outputs remain
        push_str("#14"); tx_q.push_back(8'h01); tx_q.push_back(8'h04);
        tx_q.push_back(8'h19); tx_q.push_back(8'h99); push_str("X");
        send_q(); exp_err++; check_frame("bad_cr");
        str_pay("WRITE REG");
        build_cmd(); send_q(); check_frame("after_err");

        // Short glitch between payload bytes must not create a byte
        push_str("!3A"); send_q();
        Uart_RXD = 1'b0; repeat (20) @(negedge CLK100MHZ);
        Uart_RXD = 1'b1; repeat (3 * c_BIT) @(negedge CLK100MHZ);
        check("glitch.busy", c_W'(rx_busy), c_W'(1));
        check("glitch.error_cnt", c_W'(n_err), c_W'(exp_err));
        push_str("BC"); tx_q.push_back(8'h0D); tx_q.push_back(8'h0A); send_q();
        str_pay("ABC"); expect_frame(1'b0); check_frame("glitch");

        // Low stop bit inside a payload
        push_str("#14"); tx_q.push_back(8'h01); send_q();
        send_byte(8'h04, 1'b0); exp_err++; check_frame("stop_err");

        // Junk in idle is silent; bad length digit; '!' inside a header is discarded
        push_str("Z!0#2!1Q"); tx_q.push_back(8'h0D); tx_q.push_back(8'h0A);
        send_q(); exp_err += 2; check_frame("hdr_err");

        push_str("#217"); send_q(); exp_err++; check_frame("too_long");

        pay.delete(); build_bin(1); send_q(); check_frame("len0");

        rand_pay(c_MAX_LEN); build_bin(2); send_q(); check_frame("maxlen");

        for (int r = 0; r < 3; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                rand_pay($urandom_range(1, 5)); build_bin($urandom_range(1, 3));
            end else begin
                rand_pay($urandom_range(1, 5)); build_cmd();
            end
            send_q(); check_frame($sformatf("rand%0d", r));
        end

        // Reset in the middle of payload byte 2
        push_str("#14"); tx_q.push_back(8'h01); send_q();
        send_bit(1'b0); send_bit(1'b1); Uart_RXD = 1'b0;
        repeat (c_BIT / 2) @(negedge CLK100MHZ);
        reset = 1'b1;
        repeat (10) @(negedge CLK100MHZ);
        check("midrst.busy", c_W'(rx_busy), c_W'(0));
        check("midrst.data", frame_data, '0);
        check("midrst.len", c_W'(frame_len), c_W'(0));
        exp_type = 1'b0; exp_len = '0; exp_data = '0;
        reset = 1'b0;
        send_bit(1'b0);
        Uart_RXD = 1'b1; repeat (3 * c_BIT) @(negedge CLK100MHZ);
        check("midrst.error_cnt", c_W'(n_err), c_W'(exp_err));
        pay = '{8'h01, 8'h04, 8'h19, 8'h99};
        build_bin(1); send_q(); check_frame("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_receiver.md
UART_FRAME_RECEIVER -- requirements
Module: uart_frame_receiver

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 57600, UART bit rate.
REQ-003 The block SHALL have parameter MAX_LEN, default 16, maximum decoded payload bytes per frame.
REQ-004 The block SHALL have port CLK100MHZ, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port Uart_RXD, input, 1 bit: asynchronous serial line, idle high.
REQ-007 The block SHALL have port frame_valid, output, 1 bit: one-cycle pulse when a complete frame is accepted.
REQ-008 The block SHALL have port frame_type, output, 1 bit: 0 for a '!' command frame, 1 for a '#' binary frame.
REQ-009 The block SHALL have port frame_len, output, 8 bits: decoded payload byte count.
REQ-010 The block SHALL have port frame_data, output, MAX_LEN*8 bits: payload with byte k at [8k+7:8k] and unused bytes zero.
REQ-011 The block SHALL have port frame_error, output, 1 bit: one-cycle pulse on any rejected frame.
REQ-012 The block SHALL have port rx_busy, output, 1 bit: high while the parser is not in IDLE.

Function
REQ-013 Uart_RXD SHALL pass through a 2-flop synchronizer before any use.
REQ-014 The byte receiver SHALL use 8N1 format, LSB first, with CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division; 1736 at defaults).
REQ-015 A falling edge SHALL start a byte; the start bit SHALL be re-sampled at CLKS_PER_BIT/2 and, if high, discarded as a glitch with no error.
REQ-016 Data bits SHALL be sampled at the centre of each bit; the stop bit SHALL be sampled at its centre.
REQ-017 A low stop bit SHALL be a framing error: the byte is discarded, frame_error pulses, the parser returns to IDLE, and the receiver waits for the line to go high.
REQ-018 Parser states SHALL be: IDLE, CMD_LEN, BIN_NDIG, BIN_LEN, PAYLOAD, ESCAPE, WAIT_CR, WAIT_LF.
REQ-019 IDLE: '!' (0x21) SHALL go to CMD_LEN with frame_type=0; '#' (0x23) SHALL go to BIN_NDIG with frame_type=1; any other byte SHALL be ignored silently.
REQ-020 CMD_LEN: one ASCII digit '1'..'9' SHALL set L, then go to PAYLOAD.
REQ-021 BIN_NDIG: one ASCII digit D in '1'..'3' SHALL go to BIN_LEN.
REQ-022 BIN_LEN: exactly D ASCII decimal digits, most significant first, SHALL form L = L*10 + digit, held in 10 bits.
REQ-023 After the last length digit, L = 0 SHALL go to WAIT_CR, and L > MAX_LEN SHALL be an error.
REQ-024 PAYLOAD (command frame): each byte SHALL be stored literally.
REQ-025 PAYLOAD (binary frame): byte 0x10 (DLE) SHALL go to ESCAPE without storing; any other byte SHALL be stored.
REQ-026 ESCAPE: the next byte SHALL be stored literally and the parser SHALL return to PAYLOAD.
REQ-027 Each stored byte SHALL count one toward L; when the count reaches L the parser SHALL go to WAIT_CR.
REQ-028 WAIT_CR SHALL require 0x0D and WAIT_LF SHALL require 0x0A; any other byte SHALL be an error.
REQ-029 On an accepted LF, frame_valid SHALL pulse exactly 1 cycle, on the cycle after the LF stop-bit sample.
REQ-030 With the frame_valid pulse, frame_len = L, and frame_type/frame_data SHALL update in that same cycle and hold until the next frame_valid.
REQ-031 A non-digit or out-of-range digit in CMD_LEN, BIN_NDIG or BIN_LEN SHALL be an error.
REQ-032 Error handling: frame_error pulses 1 cycle, the offending byte is discarded (even if '!' or '#'), the staging buffer is cleared, the parser goes to IDLE, and frame_valid/frame_data are unchanged.
REQ-033 The staging buffer SHALL be cleared on entry to CMD_LEN or BIN_NDIG, so unused frame_data bytes are zero.
REQ-034 frame_valid and frame_error SHALL never be asserted in the same cycle.

Reset
REQ-035 While reset is high, all state, counters and the staging buffer SHALL be cleared.
REQ-036 Reset values SHALL be: frame_valid=0, frame_type=0, frame_len=0, frame_data=0, frame_error=0, rx_busy=0, parser in IDLE, receiver waiting for a start bit.
REQ-037 Reset mid-byte or mid-frame SHALL abort it with no pulse; after release, bytes SHALL be accepted only from the next falling edge.

Verification
REQ-038 Sending "#14",01,04,19,99,CR,LF at 57600 baud -> one frame_valid, frame_type=1, frame_len=4, frame_data[31:0]=0x99190401, upper bytes zero.
REQ-039 Sending "!9WRITE REG",CR,LF -> frame_type=0, frame_len=9, frame_data[71:0] = "WRITE REG" with 'W' (0x57) in byte 0.
REQ-040 Sending "#14",10,10,04,19,99,CR,LF -> frame_len=4, frame_data[31:0]=0x99190410.
REQ-041 Sending "#14",01,04,19,99,"X" -> frame_error pulse, no frame_valid; a following valid "!9WRITE REG" frame is then accepted normally.
REQ-042 A byte with a low stop bit inside a payload -> frame_error pulse and parser returns to IDLE; a 400 ns low glitch on Uart_RXD -> no byte received and no error.
REQ-043 Asserting reset during payload byte 2 of a binary frame, then sending a full valid frame -> only the second frame produces frame_valid, with correct data.
